// File: rtl/dmem_if.sv
// Data-memory bus interface between the cpu MEM stage and a valid/ready bus.
// Turns a held load/store request into one bus transaction and stalls the cpu until it completes.
module dmem_if #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            mem_load,
   input  logic            mem_store,
   input  logic [XLEN-1:0] address,
   input  logic [XLEN-1:0] store_data,
   output logic [XLEN-1:0] load_data,
   output logic            stall,
   output logic            bus_valid,
   input  logic            bus_ready,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_rsp_valid,
   input  logic [XLEN-1:0] bus_rdata,
   output logic            fault_align,
   output logic            fault_timeout
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic          req;
   logic          aligned;
   logic          accept;
   logic          misalign;
   logic          expire;
   logic          abort;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_nx = state;
      req      = mem_load | mem_store;
      aligned  = (address[1:0] == 2'b00);
      accept   = 1'b0;
      misalign = 1'b0;
      abort    = 1'b0;
      expire   = (cnt >= CW'(TIMEOUT - 1));
      case (state)
         IDLE: begin
            accept   = req & aligned;
            misalign = req & ~aligned;
            if (accept) state_nx = REQ;
         end
         REQ: begin
            // A handshake in the final counted cycle wins over the timeout.
            if (bus_ready) begin
               state_nx = RESP;
            end else if (expire) begin
               abort    = 1'b1;
               state_nx = DONE;
            end
         end
         RESP: begin
            if (bus_rsp_valid) begin
               state_nx = DONE;
            end else if (expire) begin
               abort    = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      stall = accept | (state == REQ) | (state == RESP);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         load_data     <= '0;
         bus_valid     <= 1'b0;
         bus_we        <= 1'b0;
         bus_addr      <= '0;
         bus_wdata     <= '0;
         fault_align   <= 1'b0;
         fault_timeout <= 1'b0;
         cnt           <= '0;
      end else begin
         fault_align   <= misalign;
         fault_timeout <= abort;

         if (accept) begin
            bus_valid <= 1'b1;
            bus_we    <= mem_store;
            bus_addr  <= address;
            bus_wdata <= store_data;
            cnt       <= '0;
         end else if (state_nx == REQ || state_nx == RESP) begin
            cnt <= cnt + 1'b1;
         end

         if (state == REQ && state_nx != REQ) begin
            bus_valid <= 1'b0;
         end

         // Stores never touch load_data; an aborted read returns zero.
         if (!bus_we) begin
            if (state == RESP && bus_rsp_valid) begin
               load_data <= bus_rdata;
            end else if (abort) begin
               load_data <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_if.sv
// Directed bench for dmem_if: scripted cpu requests against a configurable bus responder,
// with expected load results queued at issue and compared when the access completes.
module tb_dmem_if;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 8;

   logic            clock;
   logic            reset;
   logic            mem_load;
   logic            mem_store;
   logic [XLEN-1:0] address;
   logic [XLEN-1:0] store_data;
   logic [XLEN-1:0] load_data;
   logic            stall;
   logic            bus_valid;
   logic            bus_ready;
   logic            bus_we;
   logic [XLEN-1:0] bus_addr;
   logic [XLEN-1:0] bus_wdata;
   logic            bus_rsp_valid;
   logic [XLEN-1:0] bus_rdata;
   logic            fault_align;
   logic            fault_timeout;

   // Responder-owned and bench-owned copies of the bus inputs, selected by auto_bus.
   logic            auto_bus;
   logic            r_ready, r_rsp;
   logic [XLEN-1:0] r_rdata;
   logic            m_ready, m_rsp;
   logic [XLEN-1:0] m_rdata;

   assign bus_ready     = auto_bus ? r_ready : m_ready;
   assign bus_rsp_valid = auto_bus ? r_rsp   : m_rsp;
   assign bus_rdata     = auto_bus ? r_rdata : m_rdata;

   int              ready_wait;
   int              rsp_wait;
   bit              never_ready;
   logic [XLEN-1:0] rd_value;
   int              hs_count;

   int              checks;
   int              failures;
   logic [XLEN-1:0] model_ld;
   logic [XLEN-1:0] sb_q[$];

   dmem_if #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .clock         (clock),
      .reset         (reset),
      .mem_load      (mem_load),
      .mem_store     (mem_store),
      .address       (address),
      .store_data    (store_data),
      .load_data     (load_data),
      .stall         (stall),
      .bus_valid     (bus_valid),
      .bus_ready     (bus_ready),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rdata     (bus_rdata),
      .fault_align   (fault_align),
      .fault_timeout (fault_timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bus slave: ready after ready_wait REQ cycles, response rsp_wait cycles after the handshake.
   initial begin : responder
      int  w;
      int  rw;
      bit  pend;
      bit  prev_valid;
      w = 0; rw = 0; pend = 0; prev_valid = 0;
      r_ready = 1'b0; r_rsp = 1'b0; r_rdata = '0;
      forever begin
         @(posedge clock);
         #2;
         if (!auto_bus || !reset) begin
            pend = 0; w = 0; r_ready = 1'b0; r_rsp = 1'b0;
            prev_valid = bus_valid;
            continue;
         end
         r_rsp = 1'b0;
         if (bus_valid && !prev_valid) pend = 0;
         if (prev_valid && r_ready) begin
            pend = 1; rw = 0; hs_count++;
         end
         if (pend) begin
            if (rw == rsp_wait) begin
               r_rsp = 1'b1; r_rdata = rd_value; pend = 0;
            end else begin
               rw++;
            end
         end
         if (bus_valid) begin
            r_ready = !never_ready && (w >= ready_wait);
            w++;
         end else begin
            r_ready = 1'b0; w = 0;
         end
         prev_valid = bus_valid;
      end
   end

   task automatic cpu_op(input string tag, input bit st, input logic [XLEN-1:0] addr,
                         input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] rdata,
                         input int rdy_w, input int rsp_w, input bit nrdy,
                         input int exp_stall, input bit exp_to);
      int n;
      logic [XLEN-1:0] exp_ld;
      ready_wait = rdy_w; rsp_wait = rsp_w; never_ready = nrdy; rd_value = rdata;
      @(negedge clock);
      mem_load = !st; mem_store = st; address = addr; store_data = wdata;
      if (!st) model_ld = exp_to ? '0 : rdata;
      sb_q.push_back(model_ld);
      #1;
      check({tag, "/to_clear"}, 32'(fault_timeout), 32'(0));
      n = 0;
      while (stall && n < 300) begin
         if (bus_valid) begin
            check({tag, "/bus_addr"}, bus_addr, addr);
            check({tag, "/bus_wdata"}, bus_wdata, wdata);
            check({tag, "/bus_we"}, 32'(bus_we), 32'(st));
         end
         n++;
         @(negedge clock);
         #1;
      end
      check({tag, "/stall_cycles"}, 32'(n), 32'(exp_stall));
      exp_ld = sb_q.pop_front();
      check({tag, "/load_data"}, load_data, exp_ld);
      check({tag, "/fault_timeout"}, 32'(fault_timeout), 32'(exp_to));
      check({tag, "/fault_align"}, 32'(fault_align), 32'(0));
   endtask

   task automatic cpu_misaligned(input string tag, input bit st, input logic [XLEN-1:0] addr);
      @(negedge clock);
      mem_load = !st; mem_store = st; address = addr; store_data = 32'hFFFF_0000;
      #1;
      check({tag, "/stall"}, 32'(stall), 32'(0));
      @(negedge clock);
      mem_load = 1'b0; mem_store = 1'b0;
      #1;
      check({tag, "/fault_align"}, 32'(fault_align), 32'(1));
      check({tag, "/bus_valid"}, 32'(bus_valid), 32'(0));
      check({tag, "/load_data"}, load_data, model_ld);
      @(negedge clock);
      #1;
      check({tag, "/align_pulse"}, 32'(fault_align), 32'(0));
      check({tag, "/bus_idle"}, 32'(bus_valid), 32'(0));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int h0;
      checks = 0; failures = 0; hs_count = 0; model_ld = '0;
      auto_bus = 1'b1; m_ready = 1'b0; m_rsp = 1'b0; m_rdata = '0;
      ready_wait = 0; rsp_wait = 0; never_ready = 0; rd_value = '0;
      reset = 1'b0; mem_load = 1'b0; mem_store = 1'b0; address = '0; store_data = '0;

      repeat (2) @(negedge clock);
      #1;
      check("rst/load_data", load_data, '0);
      check("rst/bus_valid", 32'(bus_valid), 32'(0));
      check("rst/bus_we", 32'(bus_we), 32'(0));
      check("rst/bus_addr", bus_addr, '0);
      check("rst/bus_wdata", bus_wdata, '0);
      check("rst/faults", 32'({fault_align, fault_timeout}), 32'(0));
      check("rst/stall", 32'(stall), 32'(0));
      reset = 1'b1;

      cpu_op("read0", 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 3, 0);
      cpu_op("store_bp", 1, 32'h204, 32'h55AA, 32'h0, 4, 0, 0, 7, 0);
      @(negedge clock); mem_load = 1'b0; mem_store = 1'b0;
      cpu_misaligned("mis_ld", 0, 32'h102);
      cpu_misaligned("mis_st", 1, 32'h203);

      cpu_op("to_req", 0, 32'h30, 32'h0, 32'hAAAA_5555, 0, 0, 1, TIMEOUT + 1, 1);
      cpu_op("read1", 0, 32'hA0C, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 3, 0);
      cpu_op("to_resp", 0, 32'h40, 32'h0, 32'h7777_7777, 0, 12, 0, TIMEOUT + 1, 1);
      cpu_op("rsp_last", 0, 32'h44, 32'h0, 32'h1357_2468, 0, TIMEOUT - 2, 0, TIMEOUT + 1, 0);
      cpu_op("hs_last", 0, 32'h48, 32'h0, 32'h0BAD_C0DE, TIMEOUT - 1, 0, 0, TIMEOUT + 2, 0);

      h0 = hs_count;
      cpu_op("b2b_ld", 0, 32'h50, 32'h0, 32'h1111_2222, 0, 0, 0, 3, 0);
      cpu_op("b2b_st", 1, 32'h54, 32'h3333_4444, 32'h0, 0, 0, 0, 3, 0);
      @(negedge clock); mem_load = 1'b0; mem_store = 1'b0;
      repeat (2) @(negedge clock);
      check("b2b/handshakes", 32'(hs_count - h0), 32'(2));

      auto_bus = 1'b0;
      @(negedge clock);
      mem_load = 1'b1; mem_store = 1'b0; address = 32'h300;
      @(negedge clock);
      #1;
      check("rstresp/req_valid", 32'(bus_valid), 32'(1));
      m_ready = 1'b1;
      @(negedge clock);
      m_ready = 1'b0;
      #1;
      check("rstresp/resp_valid", 32'(bus_valid), 32'(0));
      check("rstresp/resp_stall", 32'(stall), 32'(1));
      reset = 1'b0;
      mem_load = 1'b0;
      #1;
      check("rstresp/bus_valid", 32'(bus_valid), 32'(0));
      check("rstresp/load_data", load_data, '0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      m_rsp = 1'b1; m_rdata = 32'h1234_5678;
      @(negedge clock);
      m_rsp = 1'b0;
      #1;
      check("stray/load_data", load_data, '0);
      check("stray/stall", 32'(stall), 32'(0));
      check("stray/bus_valid", 32'(bus_valid), 32'(0));
      model_ld = '0;
      auto_bus = 1'b1;

      cpu_op("post_rst", 0, 32'h60, 32'h0, 32'h600D_CAFE, 0, 0, 0, 3, 0);
      @(negedge clock); mem_load = 1'b0; mem_store = 1'b0;
      repeat (2) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
